// File: rtl/agc_timepulse_gen.sv
// Timepulse/phase ring generator for the NOR-gate logic network.
// Produces one-hot T01..T(NTP) and phase rings, MCT-boundary halt, restart and a completed-MCT counter.
module agc_timepulse_gen #(
    parameter int NTP    = 12,
    parameter int NPHASE = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stop_req,
    input  logic              restart,
    output logic [NTP-1:0]    t,
    output logic [NPHASE-1:0] phs,
    output logic              mct_strobe,
    output logic              stopped,
    output logic [CNT_W-1:0]  mct_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_STOP = 1'b1;

    localparam logic [NTP-1:0]    T_FIRST = {{(NTP-1){1'b0}}, 1'b1};
    localparam logic [NPHASE-1:0] P_FIRST = {{(NPHASE-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NTP-1:0]    t_q, t_d;
    logic [NPHASE-1:0] phs_q, phs_d;
    logic [0:0]        state_q, state_d;
    logic              strobe_q, strobe_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              boundary;
    logic [NTP-1:0]    t_rot;
    logic [NPHASE-1:0] phs_rot;

    // Both rings are all-zero while halted, so the boundary can only fire in RUN.
    assign boundary = t_q[NTP-1] & phs_q[NPHASE-1];
    assign t_rot    = {t_q[NTP-2:0], t_q[NTP-1]};
    assign phs_rot  = {phs_q[NPHASE-2:0], phs_q[NPHASE-1]};

    always_comb begin
        t_d     = t_q;
        phs_d   = phs_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (restart) begin
            // Aborted MCT is not counted, even if this is a boundary edge.
            t_d     = T_FIRST;
            phs_d   = P_FIRST;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            phs_d = phs_rot;
            if (phs_q[NPHASE-1]) begin
                t_d = t_rot;
            end
            if (boundary) begin
                cnt_d = cnt_q + CNT_ONE;
                if (stop_req) begin
                    state_d = ST_STOP;
                    t_d     = '0;
                    phs_d   = '0;
                end
            end
        end else if (!stop_req) begin
            t_d     = T_FIRST;
            phs_d   = P_FIRST;
            state_d = ST_RUN;
        end

        // Strobe is derived from the next ring state so it lines up with the last MCT cycle.
        strobe_d = t_d[NTP-1] & phs_d[NPHASE-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q      <= T_FIRST;
            phs_q    <= P_FIRST;
            state_q  <= ST_RUN;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            t_q      <= t_d;
            phs_q    <= phs_d;
            state_q  <= state_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    assign t          = t_q;
    assign phs        = phs_q;
    assign mct_strobe = strobe_q;
    assign stopped    = (state_q == ST_STOP);
    assign mct_count  = cnt_q;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Self-checking bench for agc_timepulse_gen: vector table, directed corner sequences
// and random stimulus against a position-in-MCT reference model.
module tb_agc_timepulse_gen;

    localparam int NTP    = 12;
    localparam int NPHASE = 4;
    localparam int MCT    = NTP * NPHASE;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stop_req = 1'b0;
    logic              restart = 1'b0;
    logic [NTP-1:0]    t, t4;
    logic [NPHASE-1:0] phs, phs4;
    logic              mct_strobe, strobe4;
    logic              stopped, stopped4;
    logic [15:0]       mct_count;
    logic [3:0]        cnt4;

    int tests = 0;
    int fails = 0;

    // Reference model: running flag, cycle position within the MCT, completed MCT count.
    bit m_run;
    int m_pos;
    int m_cnt;

    agc_timepulse_gen #(.NTP(NTP), .NPHASE(NPHASE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stop_req(stop_req), .restart(restart),
        .t(t), .phs(phs), .mct_strobe(mct_strobe), .stopped(stopped), .mct_count(mct_count)
    );

    agc_timepulse_gen #(.NTP(NTP), .NPHASE(NPHASE), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stop_req(stop_req), .restart(restart),
        .t(t4), .phs(phs4), .mct_strobe(strobe4), .stopped(stopped4), .mct_count(cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b1;
        m_pos = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit s, input bit r);
        if (r) begin
            m_run = 1'b1;
            m_pos = 0;
        end else if (m_run) begin
            if (m_pos == MCT - 1) begin
                m_cnt++;
                m_pos = 0;
                if (s) m_run = 1'b0;
            end else begin
                m_pos++;
            end
        end else if (!s) begin
            m_run = 1'b1;
            m_pos = 0;
        end
    endtask

    task automatic check_model(input string nm);
        logic [31:0] et, ep;
        et = m_run ? (32'd1 << (m_pos / NPHASE)) : 32'd0;
        ep = m_run ? (32'd1 << (m_pos % NPHASE)) : 32'd0;
        chk({nm, ".t"}, 32'(t), et);
        chk({nm, ".phs"}, 32'(phs), ep);
        chk({nm, ".strobe"}, 32'(mct_strobe), 32'(m_run && m_pos == MCT - 1));
        chk({nm, ".stopped"}, 32'(stopped), 32'(!m_run));
        chk({nm, ".count"}, 32'(mct_count), 32'(m_cnt % 65536));
        chk({nm, ".count4"}, 32'(cnt4), 32'(m_cnt % 16));
        chk({nm, ".t4"}, 32'(t4), et);
        chk({nm, ".stopped4"}, 32'(stopped4), 32'(!m_run));
    endtask

    // One clock: inputs driven away from the edge, outputs sampled on the falling edge.
    task automatic cycle(input bit s, input bit r, input string nm);
        stop_req = s;
        restart  = r;
        @(posedge clk);
        model_step(s, r);
        @(negedge clk);
        check_model(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        stop_req = 1'b0;
        restart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_model("reset");
        rst = 1'b1;
    endtask

    typedef struct {
        bit          stop;
        bit          rs;
        int          n;
        logic [11:0] et;
        logic [3:0]  ep;
        bit          es;
        bit          estop;
        int          ecnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int hits[$];
        int k;
        bit seen;

        vecs[0] = '{0, 0, 47, 12'h800, 4'h8, 1, 0, 0};  // last cycle of first MCT
        vecs[1] = '{1, 0, 1,  12'h000, 4'h0, 0, 1, 1};  // halt at boundary, MCT counted
        vecs[2] = '{1, 0, 5,  12'h000, 4'h0, 0, 1, 1};  // stays halted
        vecs[3] = '{0, 0, 1,  12'h001, 4'h1, 0, 0, 1};  // resume at T01 phase 1
        vecs[4] = '{0, 0, 26, 12'h040, 4'h4, 0, 0, 1};  // T07 phase 3
        vecs[5] = '{0, 1, 1,  12'h001, 4'h1, 0, 0, 1};  // restart mid-MCT
        vecs[6] = '{0, 1, 3,  12'h001, 4'h1, 0, 0, 1};  // restart held
        vecs[7] = '{0, 0, 47, 12'h800, 4'h8, 1, 0, 1};
        vecs[8] = '{1, 1, 1,  12'h001, 4'h1, 0, 0, 1};  // restart beats stop at boundary
        vecs[9] = '{0, 0, 48, 12'h001, 4'h1, 0, 0, 2};

        // Table-driven vectors
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < vecs[i].n; j++) cycle(vecs[i].stop, vecs[i].rs, "vec");
            chk("vec.t", 32'(t), 32'(vecs[i].et));
            chk("vec.phs", 32'(phs), 32'(vecs[i].ep));
            chk("vec.strobe", 32'(mct_strobe), 32'(vecs[i].es));
            chk("vec.stopped", 32'(stopped), 32'(vecs[i].estop));
            chk("vec.count", 32'(mct_count), 32'(vecs[i].ecnt));
            $display("[TB] vector %0d: stop=%0b restart=%0b n=%0d -> t=%03h phs=%0h cnt=%0d",
                     i, vecs[i].stop, vecs[i].rs, vecs[i].n, t, phs, mct_count);
        end

        // Two idle MCTs: strobe on cycles 48 and 96 only, count 2
        do_reset();
        for (int c = 1; c <= 96; c++) begin
            cycle(1'b0, 1'b0, "idle");
            if (mct_strobe) hits.push_back(c + 1);
        end
        chk("idle.strobe_hits", 32'(hits.size()), 32'd2);
        if (hits.size() == 2) begin
            chk("idle.strobe_first", 32'(hits[0]), 32'd48);
            chk("idle.strobe_second", 32'(hits[1]), 32'd96);
        end
        chk("idle.count", 32'(mct_count), 32'd2);
        $display("[TB] idle run: %0d strobes, count=%0d", hits.size(), mct_count);

        // stop_req held from cycle 10 until 60: halt from cycle 49, resume on cycle 61
        do_reset();
        for (int c = 1; c <= 60; c++) begin
            cycle(c >= 10 && c < 60, 1'b0, "stop");
            if (c == 47) chk("stop.not_yet", 32'(stopped), 32'd0);
            if (c == 48) begin
                chk("stop.halted", 32'(stopped), 32'd1);
                chk("stop.t_zero", 32'(t), 32'd0);
                chk("stop.count", 32'(mct_count), 32'd1);
            end
        end
        chk("stop.resume_t", 32'(t), 32'd1);
        chk("stop.resume_phs", 32'(phs), 32'd1);
        chk("stop.resume_stopped", 32'(stopped), 32'd0);
        $display("[TB] stop/resume: t=%03h stopped=%0b cnt=%0d", t, stopped, mct_count);

        // stop_req pulsed mid-MCT only: no halt
        do_reset();
        for (int c = 1; c <= 48; c++) cycle(c >= 10 && c <= 20, 1'b0, "pulse");
        chk("pulse.stopped", 32'(stopped), 32'd0);
        chk("pulse.t", 32'(t), 32'd1);
        chk("pulse.count", 32'(mct_count), 32'd1);
        $display("[TB] mid-MCT stop pulse: stopped=%0b cnt=%0d", stopped, mct_count);

        // restart at T07 phase 3; next strobe is the 48th cycle after restart
        do_reset();
        for (int c = 1; c <= 26; c++) cycle(1'b0, 1'b0, "rs_pre");
        chk("rs.at_t07", 32'(t), 32'h040);
        chk("rs.at_ph3", 32'(phs), 32'h4);
        cycle(1'b0, 1'b1, "rs");
        chk("rs.t", 32'(t), 32'd1);
        chk("rs.count", 32'(mct_count), 32'd0);
        k = 1;
        seen = 1'b0;
        while (k < 100 && !seen) begin
            cycle(1'b0, 1'b0, "rs_post");
            k++;
            seen = mct_strobe;
        end
        chk("rs.strobe_seen", 32'(seen), 32'd1);
        chk("rs.strobe_cycle", 32'(k), 32'd48);
        $display("[TB] restart: next strobe in cycle %0d after restart", k);

        // Asynchronous reset at T09, between edges
        do_reset();
        for (int c = 1; c <= 33; c++) cycle(1'b0, 1'b0, "arst_pre");
        chk("arst.at_t09", 32'(t), 32'h100);
        #2 rst = 1'b0;
        #1;
        chk("arst.t", 32'(t), 32'd1);
        chk("arst.phs", 32'(phs), 32'd1);
        chk("arst.count", 32'(mct_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int c = 1; c <= 48; c++) cycle(1'b1, 1'b0, "arst_stop");
        chk("arst.stopped_before", 32'(stopped), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst.stop_cleared", 32'(stopped), 32'd0);
        chk("arst.stop_t", 32'(t), 32'd1);
        chk("arst.stop_count", 32'(mct_count), 32'd0);
        @(negedge clk);
        stop_req = 1'b0;
        rst = 1'b1;
        model_reset();
        $display("[TB] async reset: t=%03h stopped=%0b cnt=%0d", t, stopped, mct_count);

        // 4-bit counter wraps 15 -> 0
        do_reset();
        for (int c = 1; c <= 15 * MCT; c++) cycle(1'b0, 1'b0, "wrap");
        chk("wrap.cnt4_15", 32'(cnt4), 32'd15);
        for (int c = 1; c <= MCT; c++) cycle(1'b0, 1'b0, "wrap");
        chk("wrap.cnt4_0", 32'(cnt4), 32'd0);
        chk("wrap.cnt16", 32'(mct_count), 32'd16);
        $display("[TB] counter wrap: cnt4=%0d cnt16=%0d", cnt4, mct_count);

        // Random stimulus against the model
        do_reset();
        begin
            bit s = 1'b0;
            bit r;
            for (int c = 0; c < 2000; c++) begin
                if ($urandom_range(0, 39) == 0) s = ~s;
                r = ($urandom_range(0, 59) == 0);
                cycle(s, r, "rand");
            end
        end
        $display("[TB] random run: 2000 cycles, cnt=%0d", mct_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/agc_timepulse_gen.md
Name: agc_timepulse_gen

Overview:
- Clocked timing generator that feeds the NOR-gate logic network.
- Produces the one-hot timepulse ring T01..T12 and a one-hot phase ring within each timepulse. Gate nets qualify on these signals.
- Supports a halt at the memory-cycle-time (MCT) boundary and a synchronous restart. Counts completed MCTs for monitoring.
- All outputs are registered, so downstream NOR nets see glitch-free drives.

Parameters:
- NTP, 12, number of timepulses per MCT (≥2)
- NPHASE, 4, clock cycles (phases) per timepulse (≥2)
- CNT_W, 16, width of the completed-MCT counter

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-low: 0 resets immediately, release is synchronous to clk
- stop_req  input  1  request to halt at the next MCT boundary; level-sensitive
- restart  input  1  synchronous restart; forces T01/phase 1 on next edge
- t  output  NTP  one-hot timepulse; bit 0 = T01
- phs  output  NPHASE  one-hot phase within the current timepulse; bit 0 = phase 1
- mct_strobe  output  1  high exactly during T(NTP), phase NPHASE (last cycle of the MCT)
- stopped  output  1  generator halted; t and phs all-zero
- mct_count  output  CNT_W  completed MCTs, modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous): t=1 (T01), phs=1, mct_strobe=0, stopped=0, mct_count=0.
- Running, each edge:
  - phs rotates left by one.
  - When phs is at bit NPHASE-1: phs wraps to bit 0 and t rotates left by one.
  - When t is at bit NTP-1 and phs at NPHASE-1 (the boundary): t wraps to T01 and mct_count increments, with wrap 2^CNT_W-1 → 0.
- mct_strobe is registered. It is 1 in the same cycle that t=bit NTP-1 and phs=bit NPHASE-1, and 0 otherwise. It is 0 while stopped.
- One MCT is NTP×NPHASE cycles; 48 cycles at default settings.
- State machine has two states, RUN and STOP:
  - RUN→STOP: at a boundary edge with stop_req=1. mct_count still increments, because that MCT completed. Next cycle: stopped=1, t=0, phs=0.
  - stop_req is ignored mid-MCT; only its value at the boundary edge matters.
  - STOP→RUN: first edge with stop_req=0. Next cycle: stopped=0, t=T01, phs=phase 1. mct_count unchanged.
  - STOP→STOP: while stop_req=1. All outputs hold.
- restart=1 has priority over all except reset:
  - Next cycle t=T01, phs=phase 1, stopped=0, mct_strobe=0. Applies from any state, including STOP.
  - mct_count is not incremented, since the aborted MCT is not counted. This holds even when restart coincides with a boundary edge.
  - While restart stays 1, outputs hold T01/phase 1. Counting resumes on the first edge with restart=0.
- restart and stop_req both at a boundary: restart wins; no stop.
- Reset asserted mid-MCT or while stopped: immediate return to reset values. No partial state survives.
- Invariant: t and phs are each exactly one-hot in RUN and all-zero in STOP.

Test Plan:
- Release reset, idle inputs, run 96 cycles → t sequence T01..T12 with 4 cycles each, twice. mct_strobe high on cycles 48 and 96 only. mct_count=2.
- stop_req=1 raised at cycle 10 of an MCT → no effect until cycle 48. Then mct_count+1, stopped=1, t=0, phs=0 from cycle 49. Drop stop_req at cycle 60 → cycle 61 shows t=T01, phs=phase 1, stopped=0.
- stop_req pulsed high for cycles 10–20 only → MCT completes normally, no stop, mct_count+1.
- restart pulsed at T07 phase 3 → next cycle T01 phase 1. mct_count unchanged. The next mct_strobe occurs 48 cycles after restart deasserts.
- restart and stop_req both 1 at a boundary → T01 phase 1, stopped=0, mct_count not incremented. With CNT_W=4, run 16 MCTs from reset → mct_count wraps 15→0.
- rst driven 0 asynchronously between clock edges at T09 → outputs go to reset values before the next edge. While stopped, rst=0 → stopped=0, t=T01.
